// File: rtl/single_midi_out.sv
// single_midi_out: queued 8N1 MIDI serial transmitter.
// Bytes are written into a small FIFO and sent LSB first with one start bit
// and one stop bit; back-to-back frames are sent with no idle gap.
// Optional feature: define MIDI_RUNNING_STATUS_EN to drop repeated channel
// status bytes (running-status suppression).
module single_midi_out #(
   parameter int BYTE_W     = 8,
   parameter int MIDI_BAUD  = 31250,
   parameter int SYSCLK_F   = 48000000,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   input  logic [BYTE_W-1:0] data_tx,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic              MIDI_OUT,
   output logic              busy
);

   localparam int CLK_PER_BIT = SYSCLK_F / MIDI_BAUD;
   localparam int PTR_W       = $clog2(FIFO_DEPTH);
   localparam int CNT_W       = PTR_W + 1;
   localparam int BIT_W       = $clog2(BYTE_W) + 1;

   localparam logic [10:0]      BIT_END  = 11'(CLK_PER_BIT - 1);
   localparam logic [CNT_W-1:0] FULL     = CNT_W'(FIFO_DEPTH);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(BYTE_W - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t            state_q, state_d;
   logic [BYTE_W-1:0] fifo_q [FIFO_DEPTH];
   logic [BYTE_W-1:0] fifo_d [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [BYTE_W-1:0] shift_q, shift_d;
   logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [10:0]       clk_cnt_q, clk_cnt_d;
   logic              midi_out_q, midi_out_d;

   logic              push;
   logic              pop;
   logic              load;
   logic              drop;
   logic              not_empty;
   logic              bit_end;
   logic [BYTE_W-1:0] head;

   assign tx_ready  = (count_q != FULL);
   assign push      = tx_valid && tx_ready;
   assign not_empty = (count_q != '0);
   assign bit_end   = (clk_cnt_q == BIT_END);
   assign head      = fifo_q[rd_ptr_q];
   assign MIDI_OUT  = midi_out_q;
   assign busy      = (state_q != IDLE) || not_empty;

`ifdef MIDI_RUNNING_STATUS_EN
   logic [BYTE_W-1:0] status_q, status_d;

   function automatic logic is_channel_status(input logic [BYTE_W-1:0] b);
      return (b >= BYTE_W'(8'h80)) && (b <= BYTE_W'(8'hEF));
   endfunction

   function automatic logic is_sys_common(input logic [BYTE_W-1:0] b);
      return (b >= BYTE_W'(8'hF0)) && (b <= BYTE_W'(8'hF7));
   endfunction

   // A repeated channel status byte is popped but never put on the line.
   assign drop = is_channel_status(head) && (head == status_q);

   // Track the last transmitted channel status; system common bytes cancel it.
   always_comb begin
      status_d = status_q;
      if (pop) begin
         if (is_channel_status(head)) begin
            status_d = head;
         end else if (is_sys_common(head)) begin
            status_d = '0;
         end
      end
   end

   // Running-status register.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         status_q <= '0;
      end else begin
         status_q <= status_d;
      end
   end
`else
   assign drop = 1'b0;
`endif

   // Queue bookkeeping: write on accept, read on pop, count nets out on both.
   always_comb begin
      fifo_d = fifo_q;
      if (push) begin
         fifo_d[wr_ptr_q] = data_tx;
      end
      wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Frame sequencer: next state, bit timing, shifting and popping.
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      clk_cnt_d = ((state_q == IDLE) || bit_end) ? 11'd0 : clk_cnt_q + 11'd1;
      pop       = 1'b0;
      load      = 1'b0;
      case (state_q)
         IDLE: begin
            if (not_empty) begin
               pop = 1'b1;
               if (!drop) begin
                  load    = 1'b1;
                  state_d = START;
               end
            end
         end
         START: begin
            if (bit_end) begin
               state_d   = DATA;
               bit_cnt_d = '0;
            end
         end
         DATA: begin
            if (bit_end) begin
               shift_d   = shift_q >> 1;
               bit_cnt_d = bit_cnt_q + BIT_W'(1);
               if (bit_cnt_q == LAST_BIT) begin
                  state_d = STOP;
               end
            end
         end
         STOP: begin
            if (bit_end) begin
               state_d = IDLE;
               if (not_empty) begin
                  pop = 1'b1;
                  if (!drop) begin
                     load    = 1'b1;
                     state_d = START;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (load) begin
         shift_d   = head;
         bit_cnt_d = '0;
      end
   end

   // Line level follows the current state; registered so nothing feeds through.
   always_comb begin
      case (state_q)
         START:   midi_out_d = 1'b0;
         DATA:    midi_out_d = shift_q[0];
         default: midi_out_d = 1'b1;
      endcase
   end

   // Control and line registers; reset aborts any frame and empties the queue.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q    <= IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         clk_cnt_q  <= '0;
         midi_out_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
         clk_cnt_q  <= clk_cnt_d;
         midi_out_q <= midi_out_d;
      end
   end

   // Queue storage holds data only, so it needs no reset.
   always_ff @(posedge sys_clk) begin
      fifo_q <= fifo_d;
   end

endmodule
